// File: rtl/cache_arb_pkg.sv
// rtl/cache_arb_pkg.sv - shared types and widths for the I/D cache line arbiter
package cache_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D_R,
        GNT_D_W
    } arb_state_t;

    typedef enum logic {
        ICACHE,
        DCACHE
    } requester_t;

endpackage

// File: rtl/cache_arb_pick.sv
// rtl/cache_arb_pick.sv - tie-break between I and D requests; CACHE_ARB_ROUND_ROBIN_EN selects round-robin over fixed D priority
module cache_arb_pick
    import cache_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  requester_t last_grant,
    output requester_t winner,
    output logic       valid
);

`ifndef CACHE_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; last_grant is kept on the port so the FSM is mode-independent.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        valid  = i_req | d_req;
        winner = DCACHE;
        if (i_req && !d_req) begin
            winner = ICACHE;
        end else if (i_req && d_req) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            winner = (last_grant == ICACHE) ? DCACHE : ICACHE;
`else
            winner = DCACHE;
`endif
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one cacheline adaptor between I-cache and D-cache (CACHE_ARB_ROUND_ROBIN_EN: round-robin ties)
module cache_arbiter
    import cache_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_address_i,
    input  logic              i_read_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic [ADDR_W-1:0] m_address_o,
    output logic [LINE_W-1:0] m_line_o,
    input  logic [LINE_W-1:0] m_line_i,
    output logic              m_read_o,
    output logic              m_write_o,
    input  logic              m_resp_i
);

    arb_state_t        state_q, state_d;
    requester_t        last_grant_q;
    requester_t        winner;
    logic              pick_valid;
    logic              capture;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] line_q;

    cache_arb_pick u_pick (
        .i_req      (i_read_i),
        .d_req      (d_read_i | d_write_i),
        .last_grant (last_grant_q),
        .winner     (winner),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    capture = 1'b1;
                    if (winner == ICACHE) begin
                        state_d = GNT_I;
                    end else if (d_read_i) begin
                        state_d = GNT_D_R;
                    end else begin
                        state_d = GNT_D_W;
                    end
                end
            end
            GNT_I, GNT_D_R, GNT_D_W: begin
                if (m_resp_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ICACHE;
            addr_q       <= '0;
            line_q       <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q <= (winner == ICACHE) ? i_address_i : d_address_i;
                if (state_d == GNT_D_W) begin
                    line_q <= d_line_i;
                end
            end
            if (state_q != IDLE && m_resp_i) begin
                last_grant_q <= (state_q == GNT_I) ? ICACHE : DCACHE;
            end
        end
    end

    // Completion is combinational so the requester sees it in the adaptor's response cycle.
    assign m_address_o = addr_q;
    assign m_line_o    = line_q;
    assign m_read_o    = (state_q == GNT_I) || (state_q == GNT_D_R);
    assign m_write_o   = (state_q == GNT_D_W);
    assign i_resp_o    = (state_q == GNT_I) && m_resp_i;
    assign d_resp_o    = ((state_q == GNT_D_R) || (state_q == GNT_D_W)) && m_resp_i;
    assign i_line_o    = m_line_i;
    assign d_line_o    = m_line_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  i_address_i;
    logic         i_read_i;
    logic [255:0] i_line_o;
    logic         i_resp_o;
    logic [31:0]  d_address_i;
    logic         d_read_i;
    logic         d_write_i;
    logic [255:0] d_line_i;
    logic [255:0] d_line_o;
    logic         d_resp_o;
    logic [31:0]  m_address_o;
    logic [255:0] m_line_o;
    logic [255:0] m_line_i;
    logic         m_read_o;
    logic         m_write_o;
    logic         m_resp_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [255:0] pat_a5;
    logic [255:0] pat_rd;
    logic [31:0]  exp_addr;
    logic         exp_i;

    cache_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_address_i (i_address_i),
        .i_read_i    (i_read_i),
        .i_line_o    (i_line_o),
        .i_resp_o    (i_resp_o),
        .d_address_i (d_address_i),
        .d_read_i    (d_read_i),
        .d_write_i   (d_write_i),
        .d_line_i    (d_line_i),
        .d_line_o    (d_line_o),
        .d_resp_o    (d_resp_o),
        .m_address_o (m_address_o),
        .m_line_o    (m_line_o),
        .m_line_i    (m_line_i),
        .m_read_o    (m_read_o),
        .m_write_o   (m_write_o),
        .m_resp_i    (m_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        pat_a5 = {32{8'hA5}};
        pat_rd = {4{64'h0123_4567_89AB_CDEF}};
        reset = 1'b1;
        i_address_i = '0; i_read_i = 1'b0;
        d_address_i = '0; d_read_i = 1'b0; d_write_i = 1'b0; d_line_i = '0;
        m_line_i = 256'h5A5A; m_resp_i = 1'b0;
        tick(); tick();
        chk("rst_m_read", m_read_o, 0);
        chk("rst_m_write", m_write_o, 0);
        chk("rst_i_resp", i_resp_o, 0);
        chk("rst_d_resp", d_resp_o, 0);
        chk("rst_m_addr", m_address_o, 0);
        chk("rst_m_line", m_line_o, 0);
        chk("rst_i_line", i_line_o, 256'h5A5A);
        chk("rst_d_line", d_line_o, 256'h5A5A);
        reset = 1'b0;
        tick();

        // I-only read, adaptor response at cycle 6
        i_read_i = 1'b1; i_address_i = 32'h0000_1000; settle();
        chk("t1_c0_m_read", m_read_o, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("t1_m_read", m_read_o, 1);
            chk("t1_m_addr", m_address_o, 32'h0000_1000);
            chk("t1_i_resp_early", i_resp_o, 0);
        end
        tick();
        m_resp_i = 1'b1; m_line_i = pat_rd; settle();
        chk("t1_c6_m_read", m_read_o, 1);
        chk("t1_i_resp", i_resp_o, 1);
        chk("t1_i_line", i_line_o, pat_rd);
        chk("t1_d_resp", d_resp_o, 0);
        tick();
        m_resp_i = 1'b0; i_read_i = 1'b0; settle();
        chk("t1_idle_m_read", m_read_o, 0);
        chk("t1_idle_i_resp", i_resp_o, 0);

        // D writeback, data and address change after the grant cycle
        tick();
        d_write_i = 1'b1; d_address_i = 32'h0000_2000; d_line_i = pat_a5;
        tick();
        d_line_i = '0; d_address_i = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            settle();
            chk("t2_m_write", m_write_o, 1);
            chk("t2_m_read", m_read_o, 0);
            chk("t2_m_line", m_line_o, pat_a5);
            chk("t2_m_addr", m_address_o, 32'h0000_2000);
            chk("t2_d_resp_early", d_resp_o, 0);
            tick();
        end
        m_resp_i = 1'b1; settle();
        chk("t2_d_resp", d_resp_o, 1);
        chk("t2_i_resp", i_resp_o, 0);
        chk("t2_m_line_end", m_line_o, pat_a5);
        tick();
        m_resp_i = 1'b0; d_write_i = 1'b0; settle();
        chk("t2_idle_d_resp", d_resp_o, 0);
        chk("t2_idle_m_write", m_write_o, 0);

        // Simultaneous I and D reads straight after reset: D wins in both modes
        reset = 1'b1; tick(); reset = 1'b0;
        i_read_i = 1'b1; i_address_i = 32'h100;
        d_read_i = 1'b1; d_address_i = 32'h200;
        tick();
        chk("t3_first_addr", m_address_o, 32'h200);
        chk("t3_first_read", m_read_o, 1);
        m_resp_i = 1'b1; settle();
        chk("t3_d_resp", d_resp_o, 1);
        chk("t3_i_resp_no", i_resp_o, 0);
        tick();
        m_resp_i = 1'b0; d_read_i = 1'b0; settle();
        chk("t3_gap_read", m_read_o, 0);
        tick();
        chk("t3_second_addr", m_address_o, 32'h100);
        chk("t3_second_read", m_read_o, 1);
        m_resp_i = 1'b1; settle();
        chk("t3_i_resp", i_resp_o, 1);
        chk("t3_d_resp_no", d_resp_o, 0);
        tick();
        m_resp_i = 1'b0; i_read_i = 1'b0;

        // Sustained contention: both requests held across six transactions
        i_read_i = 1'b1; d_read_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            exp_i = (t % 2) == 1;
`else
            exp_i = 1'b0;
`endif
            exp_addr = exp_i ? 32'h100 : 32'h200;
            tick();
            chk("t4_addr", m_address_o, exp_addr);
            m_resp_i = 1'b1; settle();
            chk("t4_i_resp", i_resp_o, exp_i);
            chk("t4_d_resp", d_resp_o, !exp_i);
            tick();
            m_resp_i = 1'b0;
            if (t == 5) begin
                i_read_i = 1'b0; d_read_i = 1'b0;
            end
            settle();
            chk("t4_gap_read", m_read_o, 0);
        end

        // d_read_i and d_write_i together: read path
        tick();
        d_read_i = 1'b1; d_write_i = 1'b1; d_address_i = 32'h280;
        tick();
        chk("t5_m_read", m_read_o, 1);
        chk("t5_m_write", m_write_o, 0);
        m_resp_i = 1'b1; settle();
        chk("t5_d_resp", d_resp_o, 1);
        tick();
        m_resp_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;

        // Reset at cycle 3 of a D read, then a fresh I read
        tick();
        d_read_i = 1'b1; d_address_i = 32'h300;
        tick(); tick(); tick();
        chk("t6_pre_read", m_read_o, 1);
        reset = 1'b1; m_resp_i = 1'b1; settle();
        chk("t6_rst_read", m_read_o, 0);
        chk("t6_rst_write", m_write_o, 0);
        chk("t6_rst_d_resp", d_resp_o, 0);
        chk("t6_rst_i_resp", i_resp_o, 0);
        chk("t6_rst_addr", m_address_o, 0);
        chk("t6_rst_line", m_line_o, 0);
        tick();
        reset = 1'b0; d_read_i = 1'b0; settle();
        chk("t6_idle_resp_ignored", d_resp_o, 0);
        tick();
        m_resp_i = 1'b0;
        i_read_i = 1'b1; i_address_i = 32'h400;
        tick();
        chk("t6_new_read", m_read_o, 1);
        chk("t6_new_addr", m_address_o, 32'h400);
        m_resp_i = 1'b1; settle();
        chk("t6_new_i_resp", i_resp_o, 1);
        chk("t6_new_d_resp", d_resp_o, 0);
        tick();
        m_resp_i = 1'b0; i_read_i = 1'b0; settle();
        chk("t6_final_idle", m_read_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
